cla_pipe_addsub: RTL
====================

CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; must be a multiple of 4, minimum 8.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, operand set offered.
REQ-005 SHALL have port in_ready, output, 1, block accepts the offered operand set this cycle.
REQ-006 SHALL have port a, input, WIDTH, operand A.
REQ-007 SHALL have port b, input, WIDTH, operand B.
REQ-008 SHALL have port sub, input, 1; 0 = A+B, 1 = A-B.
REQ-009 SHALL have port cin, input, 1; carry-in for add, ignored for sub.
REQ-010 SHALL have port out_valid, output, 1, result held and valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH, result.
REQ-013 SHALL have port cout, output, 1; carry-out on add, NOT-borrow on sub.
REQ-014 SHALL have port ovf, output, 1, two's-complement overflow.
REQ-015 SHALL have port zero, output, 1, high when sum is all zeros.

Function
REQ-016 SHALL transfer input when in_valid & in_ready and output when out_valid & out_ready, both at the clock edge.
REQ-017 SHALL use a 2-stage pipeline; latency is 2 cycles from input transfer to out_valid when unstalled; throughput 1 per cycle.
REQ-018 Stage 1 SHALL register A, B' = sub ? ~b : b, c0 = sub ? 1 : cin, bitwise P = A^B', G = A&B', and per-4-bit group GP/GG.
REQ-019 Stage 2 SHALL compute group carries by two-level lookahead over GP/GG from c0, then in-group carries by 4-bit lookahead, sum = P ^ carries, and register sum/cout/ovf/zero.
REQ-020 SHALL set ovf = carry into MSB XOR carry out of MSB.
REQ-021 Stage 2 SHALL hold all outputs stable while out_valid & !out_ready.
REQ-022 SHALL set in_ready = !s1_valid | !out_valid | out_ready; this is combinational and depends on neither in_valid nor a/b.
REQ-023 When stage 2 drains and stage 1 advances in the same cycle, no result SHALL be lost or duplicated.
REQ-024 When the pipeline is full and stalled, in_ready SHALL be 0 and a, b, sub and cin SHALL be ignored.
REQ-025 Carry chains SHALL wrap modulo 2^WIDTH; cout carries bit WIDTH.

Reset
REQ-026 While rst_n is low, out_valid, sum, cout, ovf and zero SHALL be 0, s1_valid SHALL be 0, and in_ready SHALL be 1.
REQ-027 Assertion of rst_n mid-operation SHALL discard all in-flight results; the first output after release comes from a post-reset transfer.

Configuration
REQ-028 SHALL support macro CLA_PIPE_ADDSUB_SATURATE_EN; when defined, on ovf sum SHALL clamp to max positive (0x7FFF at WIDTH 16) if A is non-negative, otherwise min negative (0x8000); ovf still reports, and zero is computed after clamping.
REQ-029 Without CLA_PIPE_ADDSUB_SATURATE_EN, sum SHALL be the wrapped result and no clamp logic SHALL exist.

Structure
REQ-030 Shared package cla_pkg SHALL hold the group-size constant (4) and the group-count function WIDTH/4.
REQ-031 SHALL instantiate one sub-module, cla_group4, per group: a 4-bit lookahead producing 3 internal carries plus group P/G; the top-level group lookahead uses the same equations.

Verification
REQ-032 Add, WIDTH 16: a=0x7FFF, b=0x0001, sub=0, cin=0 -> 2 cycles later sum=0x8000, cout=0, ovf=1, zero=0 (with SATURATE_EN: sum=0x7FFF).
REQ-033 Sub: a=0x0005, b=0x0005, sub=1 -> sum=0x0000, cout=1, ovf=0, zero=1; a=0x0000, b=0x0001 -> sum=0xFFFF, cout=0.
REQ-034 Full carry ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, zero=1, ovf=0.
REQ-035 Backpressure: 4 back-to-back inputs, out_ready low for 3 cycles -> in_ready low after 2 accepted, results emerge in order with no loss or duplication, outputs stable while stalled.
REQ-036 Reset mid-flight: 2 transfers, then rst_n low for 1 cycle -> out_valid=0 at once, no stale result after release.
REQ-037 Random regression: 10k random a/b/sub/cin with random out_ready -> every sum, cout and ovf matches a behavioural reference model.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared carry-lookahead constants and the 4-bit lookahead equations.
// Both the per-group cells and the top-level group lookahead use cla4_eval.
package cla_pkg;

  localparam int GRP = 4;

  typedef struct packed {
    logic       gg;
    logic       gp;
    logic [3:1] c;
  } cla4_t;

  function automatic int num_groups(input int width);
    return width / GRP;
  endfunction

  // Carries c1..c3 inside a 4-wide block, plus block propagate/generate.
  function automatic cla4_t cla4_eval(input logic [3:0] p, input logic [3:0] g,
                                      input logic ci);
    cla4_t r;
    r.c[1] = g[0] | (p[0] & ci);
    r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    r.gp   = &p;
    r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead cell: three internal carries from the group carry-in,
// plus group propagate/generate.
module cla_group4
  import cla_pkg::*;
(
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [3:1] c,
  output logic       gp,
  output logic       gg
);

  cla4_t r;

  assign r  = cla4_eval(p, g, ci);
  assign c  = r.c;
  assign gp = r.gp;
  assign gg = r.gg;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Define CLA_PIPE_ADDSUB_SATURATE_EN to clamp overflowing results to max/min.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG  = num_groups(WIDTH);
  localparam int NSG = (NG + GRP - 1) / GRP;

  // ---------------- stage 1: operand conditioning and group P/G
  logic [WIDTH-1:0] b_d, p_d, g_d;
  logic             c0_d;
  logic [NG-1:0]    gp_d, gg_d;

  assign b_d  = sub ? ~b : b;
  assign c0_d = sub | cin;
  assign p_d  = a ^ b_d;
  assign g_d  = a & b_d;

  always_comb begin
    cla4_t r1;
    r1   = '0;
    gp_d = '0;
    gg_d = '0;
    for (int i = 0; i < NG; i++) begin
      r1      = cla4_eval(p_d[i*GRP +: GRP], g_d[i*GRP +: GRP], 1'b0);
      gp_d[i] = r1.gp;
      gg_d[i] = r1.gg;
    end
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_p, s1_g;
  logic             s1_c0;
  logic [NG-1:0]    s1_gp, s1_gg;
  logic             s2_adv;

  assign s2_adv   = !out_valid | out_ready;
  assign in_ready = !s1_valid | !out_valid | out_ready;

  // ---------------- stage 2: group lookahead (blocks of 4 groups, chained)
  logic [NSG*GRP-1:0] gp_pad, gg_pad;
  logic [NSG*GRP:0]   gc_pad;
  logic [NG:0]        gc;

  always_comb begin
    cla4_t r2;
    logic  c_run;
    r2        = '0;
    gp_pad    = '0;
    gg_pad    = '0;
    gp_pad[NG-1:0] = s1_gp;
    gg_pad[NG-1:0] = s1_gg;
    gc_pad    = '0;
    c_run     = s1_c0;
    gc_pad[0] = s1_c0;
    for (int sg = 0; sg < NSG; sg++) begin
      r2 = cla4_eval(gp_pad[sg*GRP +: GRP], gg_pad[sg*GRP +: GRP], c_run);
      gc_pad[sg*GRP+1] = r2.c[1];
      gc_pad[sg*GRP+2] = r2.c[2];
      gc_pad[sg*GRP+3] = r2.c[3];
      c_run = r2.gg | (r2.gp & c_run);
      gc_pad[sg*GRP+GRP] = c_run;
    end
  end

  assign gc = gc_pad[NG:0];

  // In-group carries, one lookahead cell per 4-bit group
  logic [WIDTH-1:0]    cv;
  logic [NG-1:0][3:1]  ic;
  logic [NG-1:0]       igp, igg;

  for (genvar i = 0; i < NG; i++) begin : g_grp
    cla_group4 u_grp (
      .p  (s1_p[i*GRP +: GRP]),
      .g  (s1_g[i*GRP +: GRP]),
      .ci (gc[i]),
      .c  (ic[i]),
      .gp (igp[i]),
      .gg (igg[i])
    );
    assign cv[i*GRP]          = gc[i];
    assign cv[i*GRP+1 +: 3]   = ic[i];
  end

  logic [WIDTH-1:0] sum_w, sum_n;
  logic             cout_w, ovf_w;

  assign sum_w  = s1_p ^ cv;
  assign cout_w = gc[NG];
  assign ovf_w  = cv[WIDTH-1] ^ gc[NG];

  // Group P/G from the cells duplicates the stage-1 registers; only the carries are consumed.
  logic unused_s2;
`ifdef CLA_PIPE_ADDSUB_SATURATE_EN
  // Overflow always flips the sign away from A, so A's sign picks the rail.
  assign sum_n     = !ovf_w ? sum_w :
                     s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign unused_s2 = ^{s1_a[WIDTH-2:0], igp, igg};
`else
  assign sum_n     = sum_w;
  assign unused_s2 = ^{s1_a, igp, igg};
`endif

  // ---------------- pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_p      <= '0;
      s1_g      <= '0;
      s1_c0     <= 1'b0;
      s1_gp     <= '0;
      s1_gg     <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a  <= a;
          s1_p  <= p_d;
          s1_g  <= g_d;
          s1_c0 <= c0_d;
          s1_gp <= gp_d;
          s1_gg <= gg_d;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          sum  <= sum_n;
          cout <= cout_w;
          ovf  <= ovf_w;
          zero <= ~|sum_n;
        end
      end
    end
  end

endmodule
